// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
//
// Contents:
//   lsu_state_e  - controller states (IDLE/REQ/WAIT/HOLD)
//   lsu_size_e   - access size encoding (byte/half/word/double)
//   lsu_op_t     - one registered memory op as taken from the EX/MEM latch
//
// lsu_op_t is sized for the widest supported configuration (64-bit data and
// addresses); narrower instances zero-extend into it and use the low bits.
package lsu_pkg;

    localparam int LSU_MAX_XLEN = 64;
    localparam int LSU_MAX_ADDR = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic                    is_mem;
        logic                    is_store;
        lsu_size_e               size;
        logic                    is_unsigned;
        logic [LSU_MAX_ADDR-1:0] addr;
        logic [LSU_MAX_XLEN-1:0] wdata;
        logic [LSU_MAX_XLEN-1:0] alu;
    } lsu_op_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//
// Ports:
//   addr        in   effective byte address
//   size        in   access size
//   is_unsigned in   zero-extend loads instead of sign-extending
//   wdata       in   store data, right-justified
//   rdata       in   aligned word returned by the cache
//   line_addr   out  addr with the in-word byte offset cleared
//   wstrb       out  byte strobes for the access
//   wdata_lane  out  store data shifted into its byte lanes
//   rdata_ext   out  selected load bytes, right-justified and extended
//   misaligned  out  access crosses its natural alignment (or D on 32-bit)
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  lsu_size_e         size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [ADDR_W-1:0] line_addr,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misaligned
);

    localparam int LANE_W = $clog2(XLEN / 8);

    logic [LANE_W-1:0] lane;
    logic [LANE_W+2:0] bit_sh;
    logic [15:0]       strb_base;
    logic [15:0]       strb_sh;
    logic [XLEN-1:0]   rdata_sh;

    always_comb begin
        lane      = addr[LANE_W-1:0];
        bit_sh    = {lane, 3'b000};
        line_addr = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

        strb_base = 16'h0001;
        case (size)
            SZ_B: strb_base = 16'h0001;
            SZ_H: strb_base = 16'h0003;
            SZ_W: strb_base = 16'h000F;
            SZ_D: strb_base = 16'h00FF;
            default: strb_base = 16'h0001;
        endcase
        // Strobes and data that run past the top lane are simply dropped;
        // only a misaligned op with pass-through enabled can get there.
        strb_sh    = strb_base << lane;
        wstrb      = strb_sh[XLEN/8-1:0];
        wdata_lane = wdata << bit_sh;

        rdata_sh  = rdata >> bit_sh;
        rdata_ext = rdata_sh;
        case (size)
            SZ_B: rdata_ext = is_unsigned ? XLEN'(rdata_sh[7:0])
                                          : XLEN'($signed(rdata_sh[7:0]));
            SZ_H: rdata_ext = is_unsigned ? XLEN'(rdata_sh[15:0])
                                          : XLEN'($signed(rdata_sh[15:0]));
            SZ_W: rdata_ext = is_unsigned ? XLEN'(rdata_sh[31:0])
                                          : XLEN'($signed(rdata_sh[31:0]));
            default: rdata_ext = rdata_sh;
        endcase

        misaligned = 1'b0;
        case (size)
            SZ_B: misaligned = 1'b0;
            SZ_H: misaligned = addr[0];
            SZ_W: misaligned = |addr[1:0];
            // A doubleword cannot exist on a 32-bit datapath.
            SZ_D: misaligned = (XLEN == 32) ? 1'b1 : |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store controller between the EX/MEM latch and the D-cache.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   op_*             op from the EX/MEM latch (valid/ready)
//   dc_req_*         request to the data cache (valid/ready)
//   dc_resp_*        single-cycle response / write acknowledge from the cache
//   res_*            result toward the MEM/WB latch (valid/ready)
//   dbg_state        current controller state
//
// Handshakes: every valid/ready pair transfers on a cycle where both are 1.
// A producer holding valid keeps its payload stable until that cycle, and
// ready is never a precondition for raising valid.
//
// ADDR_W must not exceed 64 (the registered op is sized for 64-bit addresses).
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int ADDR_W           = 64,
    parameter bit ALLOW_MISALIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_is_mem,
    input  logic              op_is_store,
    input  logic [1:0]        op_size,
    input  logic              op_unsigned,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [XLEN-1:0]   op_wdata,
    input  logic [XLEN-1:0]   op_alu,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_req_write,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [XLEN/8-1:0] dc_req_wstrb,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   res_data,
    output logic              res_misaligned,
    output lsu_state_e        dbg_state
);

    lsu_state_e      state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            res_mis_q, res_mis_d;

    logic [ADDR_W-1:0] al_addr;
    lsu_size_e         al_size;
    logic [ADDR_W-1:0] al_line_addr;
    logic [XLEN/8-1:0] al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic              al_mis;
    logic              capture;

    // In IDLE the aligner looks at the incoming op so the misalignment
    // decision can be made in the accept cycle; afterwards it works from the
    // registered op, which keeps every dc_req_* field stable while stalled.
    always_comb begin
        if (state_q == IDLE) begin
            al_addr = op_addr;
            al_size = lsu_size_e'(op_size);
        end else begin
            al_addr = op_q.addr[ADDR_W-1:0];
            al_size = op_q.size;
        end
    end

    lsu_align #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_align (
        .addr        (al_addr),
        .size        (al_size),
        .is_unsigned (op_q.is_unsigned),
        .wdata       (op_q.wdata[XLEN-1:0]),
        .rdata       (dc_resp_rdata),
        .line_addr   (al_line_addr),
        .wstrb       (al_wstrb),
        .wdata_lane  (al_wdata),
        .rdata_ext   (al_rdata),
        .misaligned  (al_mis)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_mis_d  = res_mis_q;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d.is_mem      = op_is_mem;
                    op_d.is_store    = op_is_store;
                    op_d.size        = lsu_size_e'(op_size);
                    op_d.is_unsigned = op_unsigned;
                    op_d.addr        = LSU_MAX_ADDR'(op_addr);
                    op_d.wdata       = LSU_MAX_XLEN'(op_wdata);
                    op_d.alu         = LSU_MAX_XLEN'(op_alu);
                    res_data_d       = '0;
                    res_mis_d        = 1'b0;
                    if (!op_is_mem) begin
                        state_d = HOLD;
                    end else if (al_mis && !ALLOW_MISALIGNED) begin
                        res_mis_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dc_req_ready) begin
                    // A zero-latency cache answers in the accept cycle.
                    if (dc_resp_valid) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dc_resp_valid) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // For stores the response is only a write acknowledge.
        if (capture) begin
            res_data_d = op_q.is_store ? '0 : al_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            res_data_q <= '0;
            res_mis_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_mis_q  <= res_mis_d;
        end
    end

    always_comb begin
        op_ready       = (state_q == IDLE);
        dc_req_valid   = (state_q == REQ);
        dc_req_write   = dc_req_valid & op_q.is_store;
        dc_req_addr    = dc_req_valid ? al_line_addr : '0;
        dc_req_wdata   = dc_req_valid ? al_wdata : '0;
        dc_req_wstrb   = dc_req_valid ? al_wstrb : '0;
        res_valid      = (state_q == HOLD);
        // Non-memory ops forward the registered ALU value directly; the op
        // register resets to zero so this also reads 0 out of reset.
        res_data       = op_q.is_mem ? res_data_q : op_q.alu[XLEN-1:0];
        res_misaligned = res_mis_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;

    logic              clk;
    logic              reset;
    logic              op_valid;
    logic              op_ready;
    logic              op_is_mem;
    logic              op_is_store;
    logic [1:0]        op_size;
    logic              op_unsigned;
    logic [ADDR_W-1:0] op_addr;
    logic [XLEN-1:0]   op_wdata;
    logic [XLEN-1:0]   op_alu;
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [XLEN-1:0]   dc_req_wdata;
    logic [XLEN/8-1:0] dc_req_wstrb;
    logic              dc_resp_valid;
    logic [XLEN-1:0]   dc_resp_rdata;
    logic              res_valid;
    logic              res_ready;
    logic [XLEN-1:0]   res_data;
    logic              res_misaligned;
    lsu_state_e        dbg_state;

    logic [XLEN-1:0] exp_q[$];
    logic            exp_mis_q[$];

    int checks;
    int errors;

    mem_stage_lsu #(
        .XLEN             (XLEN),
        .ADDR_W           (ADDR_W),
        .ALLOW_MISALIGNED (1'b0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_is_mem      (op_is_mem),
        .op_is_store    (op_is_store),
        .op_size        (op_size),
        .op_unsigned    (op_unsigned),
        .op_addr        (op_addr),
        .op_wdata       (op_wdata),
        .op_alu         (op_alu),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_write   (dc_req_write),
        .dc_req_addr    (dc_req_addr),
        .dc_req_wdata   (dc_req_wdata),
        .dc_req_wstrb   (dc_req_wstrb),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_rdata  (dc_resp_rdata),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_misaligned (res_misaligned),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks (all start and end just after a negedge)

    task automatic apply_reset();
        reset         = 1'b0;
        op_valid      = 1'b0;
        op_is_mem     = 1'b0;
        op_is_store   = 1'b0;
        op_size       = 2'd0;
        op_unsigned   = 1'b0;
        op_addr       = '0;
        op_wdata      = '0;
        op_alu        = '0;
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;
        dc_resp_rdata = '0;
        res_ready     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_op(input logic is_mem, input logic is_store,
                           input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] alu);
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_op_ready: got %b want 1", op_ready);
        end
        op_valid    = 1'b1;
        op_is_mem   = is_mem;
        op_is_store = is_store;
        op_size     = size;
        op_unsigned = uns;
        op_addr     = addr;
        op_wdata    = wdata;
        op_alu      = alu;
        @(negedge clk);
        op_valid = 1'b0;
        op_addr  = $urandom();
        op_wdata = $urandom();
        op_alu   = $urandom();
    endtask

    // Plays the cache: checks the request, stalls it, then acknowledges.
    task automatic serve_cache(input logic [63:0] exp_addr, input logic exp_write,
                               input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                               input int stall, input logic [63:0] rdata,
                               input int resp_delay, input logic same_cycle);
        int n;
        n = 0;
        while (dc_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dc_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: dc_req_valid=%b after %0d cycles", dc_req_valid, n);
            return;
        end
        for (int c = 0; c <= stall; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (dc_req_valid !== 1'b1 || dc_req_addr !== exp_addr || dc_req_write !== exp_write ||
                dc_req_wstrb !== exp_strb || (exp_write && dc_req_wdata !== exp_wdata)) begin
                errors++;
                $display("FAIL req_fields[c%0d]: valid=%b addr=%h write=%b strb=%h wdata=%h want addr=%h write=%b strb=%h wdata=%h",
                         c, dc_req_valid, dc_req_addr, dc_req_write, dc_req_wstrb, dc_req_wdata,
                         exp_addr, exp_write, exp_strb, exp_wdata);
            end
        end
        dc_req_ready = 1'b1;
        if (same_cycle) begin
            dc_resp_valid = 1'b1;
            dc_resp_rdata = rdata;
        end
        @(negedge clk);
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;
        if (!same_cycle) begin
            repeat (resp_delay) begin
                checks++;
                if (dc_req_valid !== 1'b0 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_idle_outputs: req_valid=%b res_valid=%b want 0 0",
                             dc_req_valid, res_valid);
                end
                @(negedge clk);
            end
            dc_resp_valid = 1'b1;
            dc_resp_rdata = rdata;
            @(negedge clk);
            dc_resp_valid = 1'b0;
            dc_resp_rdata = $urandom();
        end
    endtask

    // Scoreboard side: waits for a result, compares it to the queue head,
    // optionally holds res_ready low, then releases it.
    task automatic collect(input int hold);
        int n;
        logic [XLEN-1:0] exp_data;
        logic            exp_mis;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL res_timeout: res_valid=%b queued=%0d", res_valid, exp_q.size());
            return;
        end
        exp_data = exp_q.pop_front();
        exp_mis  = exp_mis_q.pop_front();
        for (int c = 0; c <= hold; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data || res_misaligned !== exp_mis ||
                op_ready !== 1'b0 || dc_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL result[c%0d]: valid=%b data=%h mis=%b op_ready=%b req=%b want 1 %h %b 0 0",
                         c, res_valid, res_data, res_misaligned, op_ready, dc_req_valid,
                         exp_data, exp_mis);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL release: res_valid=%b op_ready=%b state=%0d want 0 1 0",
                     res_valid, op_ready, dbg_state);
        end
    endtask

    // Reference load extraction, written from the bit-level description.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] lane,
                                               input logic [1:0] size, input logic uns);
        logic [63:0] s;
        int          nbits;
        s     = rdata >> (8 * lane);
        nbits = 8 << size;
        for (int i = nbits; i < 64; i++) s[i] = uns ? 1'b0 : s[nbits-1];
        return s;
    endfunction

    // ---------------- tests

    task automatic test_reset();
        checks++;
        if (op_ready !== 1'b1 || dc_req_valid !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 ||
            res_misaligned !== 1'b0 || dc_req_write !== 1'b0 || dc_req_addr !== '0 ||
            dc_req_wdata !== '0 || dc_req_wstrb !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: op_ready=%b req=%b res_valid=%b data=%h mis=%b write=%b addr=%h wdata=%h strb=%h state=%0d",
                     op_ready, dc_req_valid, res_valid, res_data, res_misaligned, dc_req_write,
                     dc_req_addr, dc_req_wdata, dc_req_wstrb, dbg_state);
        end
    endtask

    task automatic test_load_byte();
        send_op(1, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h0);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
        exp_mis_q.push_back(1'b0);
        serve_cache(64'h1000, 0, 8'h08, 64'h0, 0, 64'h0000_0000_80FF_0000, 1, 0);
        collect(0);
        send_op(1, 0, 2'd0, 1, 64'h1003, 64'h0, 64'h0);
        exp_q.push_back(64'h80);
        exp_mis_q.push_back(1'b0);
        serve_cache(64'h1000, 0, 8'h08, 64'h0, 0, 64'h0000_0000_80FF_0000, 2, 0);
        collect(0);
    endtask

    task automatic test_store_half();
        send_op(1, 1, 2'd1, 0, 64'h2006, 64'hABCD, 64'h0);
        exp_q.push_back(64'h0);
        exp_mis_q.push_back(1'b0);
        serve_cache(64'h2000, 1, 8'hC0, 64'hABCD_0000_0000_0000, 3, 64'hDEAD_BEEF_DEAD_BEEF, 1, 0);
        collect(0);
    endtask

    task automatic test_misaligned();
        send_op(1, 0, 2'd2, 0, 64'h3002, 64'h0, 64'h0);
        exp_q.push_back(64'h0);
        exp_mis_q.push_back(1'b1);
        checks++;
        if (res_valid !== 1'b1 || res_misaligned !== 1'b1 || dc_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_latency: res_valid=%b mis=%b req=%b want 1 1 0",
                     res_valid, res_misaligned, dc_req_valid);
        end
        collect(1);
        send_op(1, 1, 2'd3, 0, 64'h4004, 64'h1234, 64'h0);
        exp_q.push_back(64'h0);
        exp_mis_q.push_back(1'b1);
        collect(0);
    endtask

    task automatic test_passthrough();
        send_op(0, 0, 2'd0, 0, 64'h0, 64'h0, 64'h55);
        exp_q.push_back(64'h55);
        exp_mis_q.push_back(1'b0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 64'h55) begin
            errors++;
            $display("FAIL passthrough_latency: res_valid=%b data=%h want 1 55", res_valid, res_data);
        end
        collect(0);
    endtask

    task automatic test_backpressure();
        send_op(1, 0, 2'd2, 0, 64'h5004, 64'h0, 64'h0);
        exp_q.push_back(64'hFFFF_FFFF_8765_4321);
        exp_mis_q.push_back(1'b0);
        serve_cache(64'h5000, 0, 8'hF0, 64'h0, 1, 64'h8765_4321_0000_0000, 0, 0);
        collect(4);
    endtask

    task automatic test_zero_latency();
        send_op(1, 0, 2'd3, 0, 64'h6008, 64'h0, 64'h0);
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        exp_mis_q.push_back(1'b0);
        serve_cache(64'h6008, 0, 8'hFF, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 0, 1);
        collect(0);
    endtask

    task automatic test_reset_in_wait();
        int n;
        send_op(1, 0, 2'd2, 0, 64'h7000, 64'h0, 64'h0);
        n = 0;
        while (dc_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0;
        checks++;
        if (dbg_state !== WAIT) begin
            errors++;
            $display("FAIL reach_wait: state=%0d want %0d", dbg_state, WAIT);
        end
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        dc_resp_valid = 1'b0;
        repeat (3) begin
            checks++;
            if (res_valid !== 1'b0 || op_ready !== 1'b1 || res_data !== '0) begin
                errors++;
                $display("FAIL stale_resp: res_valid=%b op_ready=%b data=%h want 0 1 0",
                         res_valid, op_ready, res_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  size;
        logic        store;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [2:0]  lane;
        logic [7:0]  strb;
        for (int i = 0; i < 16; i++) begin
            size  = 2'($urandom_range(0, 3));
            store = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            addr  = {$urandom(), $urandom()};
            addr  = addr & ~((64'd1 << size) - 64'd1);
            wdata = {$urandom(), $urandom()};
            rdata = {$urandom(), $urandom()};
            lane  = addr[2:0];
            strb  = 8'(((16'd1 << (1 << size)) - 16'd1) << lane);
            send_op(1, store, size, uns, addr, wdata, 64'h0);
            exp_q.push_back(store ? 64'h0 : model_load(rdata, lane, size, uns));
            exp_mis_q.push_back(1'b0);
            serve_cache({addr[63:3], 3'b000}, store, strb, wdata << (8 * lane),
                        $urandom_range(0, 2), rdata, $urandom_range(0, 2),
                        1'($urandom_range(0, 1)));
            collect($urandom_range(0, 2));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        apply_reset();
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_passthrough();
        test_backpressure();
        test_zero_latency();
        test_reset_in_wait();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised load/store controller for the MEM pipeline stage, between the EX/MEM latch and the data cache.
- Accepts one memory op at a time from EX.
- For stores: aligns the store data and builds byte strobes.
- For loads: extracts and sign- or zero-extends the loaded bytes.
- Detects misaligned accesses.
- Holds the result until the MEM/WB latch has consumed it.
- Replaces the fixed 64-bit, load-only handler with an explicit FSM, a valid/ready handshake and store support.

Parameters:
- XLEN, 64, data/register width in bits; must be 32 or 64.
- ADDR_W, 64, address width in bits.
- ALLOW_MISALIGNED, 0, 1 = pass misaligned ops to cache unchanged; 0 = trap without a cache request.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX/MEM latch holds a valid op.
- op_ready  out  1  LSU accepts the op this cycle.
- op_is_mem  in  1  op accesses memory; 0 = pass-through.
- op_is_store  in  1  1 = store, 0 = load.
- op_size  in  2  0=B, 1=H, 2=W, 3=D; D is illegal when XLEN=32.
- op_unsigned  in  1  zero-extend the load result.
- op_addr  in  ADDR_W  effective address (ALU result).
- op_wdata  in  XLEN  store data (reg B contents).
- op_alu  in  XLEN  ALU result, forwarded for non-memory ops.
- dc_req_valid  out  1  cache request valid.
- dc_req_ready  in  1  cache accepts the request.
- dc_req_write  out  1  request is a store.
- dc_req_addr  out  ADDR_W  op_addr with the low log2(XLEN/8) bits cleared.
- dc_req_wdata  out  XLEN  store data shifted into its byte lanes.
- dc_req_wstrb  out  XLEN/8  byte strobes.
- dc_resp_valid  in  1  cache response; single-cycle pulse.
- dc_resp_rdata  in  XLEN  aligned line word.
- res_valid  out  1  result valid toward the MEM/WB latch.
- res_ready  in  1  MEM/WB latch takes the result.
- res_data  out  XLEN  load result, or op_alu for non-memory ops, or 0 for stores.
- res_misaligned  out  1  misaligned-access trap flag, qualified by res_valid.

Behaviour:
- Reset: while reset=0, the FSM is forced to IDLE.
  - Outputs: op_ready=1, dc_req_valid=0, res_valid=0, res_data=0, res_misaligned=0.
  - Other dc_req_* outputs are 0.
- Reset mid-operation: asserting reset in any state aborts the op. A later dc_resp_valid pulse is ignored while in IDLE.
- States: IDLE, REQ, WAIT, HOLD.
- op_ready=1 only in IDLE. An op is accepted when op_valid & op_ready.
- IDLE on accept, all fields are registered:
  - !op_is_mem: res_data=op_alu, go to HOLD. Latency is 1 cycle to res_valid.
  - Misaligned and ALLOW_MISALIGNED=0: res_misaligned=1, res_data=0, go to HOLD. No cache request is made.
  - Otherwise go to REQ.
- Misaligned means addr[0] for H, |addr[1:0] for W, |addr[2:0] for D. Illegal D when XLEN=32 is treated as misaligned.
- REQ: dc_req_valid=1, with all dc_req_* outputs stable until dc_req_ready.
  - On dc_req_ready: go to WAIT.
  - If dc_resp_valid is also high in the same cycle (zero-latency cache), capture the response and go directly to HOLD.
- WAIT: on dc_resp_valid, capture and go to HOLD.
  - Load: res_data = extract(dc_resp_rdata, lane=addr[low bits], size), sign-extended unless op_unsigned.
  - Store: res_data=0. dc_resp_valid serves as the write acknowledge.
- HOLD: res_valid=1 and res_data stays stable.
  - On res_ready: go to IDLE.
  - op_ready stays 0 in HOLD, so there is no back-to-back accept in the release cycle. Maximum throughput is one op per 2 cycles plus cache latency.
- Strobes: wstrb = ((1<<(1<<size))-1) << lane. wdata = op_wdata << (8*lane). Both are truncated to XLEN.
- dc_resp_valid outside WAIT (and outside the REQ accept cycle) is ignored.
- res_ready while res_valid=0 has no effect.

Decomposition:
- Shared package lsu_pkg holds:
  - the lsu_state_e enum (IDLE/REQ/WAIT/HOLD);
  - the op-size enum (SZ_B/SZ_H/SZ_W/SZ_D);
  - the lsu_op_t packed struct (is_mem, is_store, size, unsigned, addr, wdata, alu).
- One combinational sub-module lsu_align handles strobe/wdata lane shifting, load extract/extend and misalignment detect, parametrised by XLEN and ADDR_W.
- The FSM and registers live in mem_stage_lsu.

Test Plan:
- Load byte, XLEN=64, addr=0x1003, rdata=0x0000_0000_80FF_0000, op_unsigned=0 -> dc_req_addr=0x1000, res_data=0xFFFF_FFFF_FFFF_FF80.
- Same access with op_unsigned=1 -> res_data=0x80.
- Store half, addr=0x2006, wdata=0xABCD -> dc_req_wstrb=0xC0, dc_req_wdata=0xABCD_0000_0000_0000, dc_req_write=1.
- Store handshake: with dc_req_ready held low for 3 cycles, dc_req_* stay constant. After dc_resp_valid, res_valid=1 and res_data=0.
- Load word at addr=0x3002 with ALLOW_MISALIGNED=0 -> no dc_req_valid ever, res_misaligned=1 one cycle after accept.
- Non-memory op with op_alu=0x55 -> res_data=0x55 one cycle after accept.
- Backpressure: res_ready held low for 4 cycles -> res_valid and res_data stable, op_ready=0.
- Reset pulse in WAIT -> all outputs return to reset values. A following dc_resp_valid produces no res_valid.
